niu_sii_dma_req_tx: RTL and testbench

//  NIU-side transmitter of DMA requests onto the NIU->SII inbound interface; sits directly upstream of SII.

---
 rtl/niu_sii_pkg.sv | 32 +++
 rtl/niu_sii_dma_req_tx_if.sv | 49 ++++
 rtl/niu_sii_cred_cnt.sv | 46 ++++
 rtl/niu_sii_dma_req_tx.sv | 218 +++++++++++++++++++++
 tb/tb_niu_sii_dma_req_tx.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/niu_sii_pkg.sv
// rtl/niu_sii_pkg.sv - shared types, constants and helpers for the NIU->SII DMA request transmitter
package niu_sii_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HDR     = 2'd2,
    ST_PAYLOAD = 2'd3
  } niu_sii_state_e;

  localparam int HDR_TAG_LSB = 64;
  localparam int BEATS       = 4;

  // Header layout: tag in [79:64], zero-extended PA in [63:0], everything else zero.
  function automatic logic [127:0] build_hdr(input logic [15:0] tag, input logic [63:0] pa);
    logic [127:0] h;
    h = '0;
    h[HDR_TAG_LSB +: 16] = tag;
    h[63:0] = pa;
    return h;
  endfunction

  // Odd parity per 16-bit lane: an all-zero lane yields a 1.
  function automatic logic [7:0] calc_par(input logic [127:0] d);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) begin
      p[i] = ~^d[16*i +: 16];
    end
    return p;
  endfunction

endpackage

// File: rtl/niu_sii_dma_req_tx_if.sv
// rtl/niu_sii_dma_req_tx_if.sv - DMA request, write beat, SII credit and SII transmit bundle
interface niu_sii_dma_req_tx_if #(
  parameter int PA_W  = 40,
  parameter int TAG_W = 16
) ();

  logic             req_vld;
  logic             req_rdy;
  logic             req_wr;
  logic             req_bypass;
  logic [TAG_W-1:0] req_tag;
  logic [PA_W-1:0]  req_pa;

  logic             wdata_vld;
  logic             wdata_rdy;
  logic [127:0]     wdata;
  logic [15:0]      wdata_be;

  logic             sii_niu_oqdq;
  logic             sii_niu_bqdq;

  logic             niu_sii_hdr_vld;
  logic             niu_sii_reqbypass;
  logic             niu_sii_datareq;
  logic             niu_sii_datareq16;
  logic [127:0]     niu_sii_data;
  logic [7:0]       niu_sii_parity;
  logic [15:0]      niu_sii_be;
  logic             cred_err;

  modport master (
    output req_vld, req_wr, req_bypass, req_tag, req_pa,
    output wdata_vld, wdata, wdata_be,
    output sii_niu_oqdq, sii_niu_bqdq,
    input  req_rdy, wdata_rdy,
    input  niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16,
    input  niu_sii_data, niu_sii_parity, niu_sii_be, cred_err
  );

  modport slave (
    input  req_vld, req_wr, req_bypass, req_tag, req_pa,
    input  wdata_vld, wdata, wdata_be,
    input  sii_niu_oqdq, sii_niu_bqdq,
    output req_rdy, wdata_rdy,
    output niu_sii_hdr_vld, niu_sii_reqbypass, niu_sii_datareq, niu_sii_datareq16,
    output niu_sii_data, niu_sii_parity, niu_sii_be, cred_err
  );

endinterface

// File: rtl/niu_sii_cred_cnt.sv
// rtl/niu_sii_cred_cnt.sv - saturating SII queue credit counter with sticky overflow error
module niu_sii_cred_cnt #(
  parameter int MAX = 16
) (
  input  logic iol2clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic avail,
  output logic err
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;
  logic         err_q;

  // Credit count: simultaneous inc/dec cancel; inc at MAX holds and flags an error.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      cnt_q <= W'(MAX);
      err_q <= 1'b0;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (cnt_q == W'(MAX)) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + W'(1);
          end
        end
        2'b01: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign avail = (cnt_q != '0);
  assign err   = err_q;

endmodule

// File: rtl/niu_sii_dma_req_tx.sv
// rtl/niu_sii_dma_req_tx.sv - NIU DMA request transmitter to SII (optional NIU_SII_PAR_INJ_EN parity injection)
module niu_sii_dma_req_tx
  import niu_sii_pkg::*;
#(
  parameter int OQ_CREDITS = 16,
  parameter int BQ_CREDITS = 16,
  parameter int PA_W       = 40,
  parameter int TAG_W      = 16
) (
  input logic iol2clk,
  input logic rst,
`ifdef NIU_SII_PAR_INJ_EN
  input logic inj_par_err,
`endif
  niu_sii_dma_req_tx_if.slave bus
);

  niu_sii_state_e state_q, state_d;

  logic [TAG_W-1:0] tag_q;
  logic [PA_W-1:0]  pa_q;
  logic             wr_q;
  logic             byp_q;

  logic [127:0] wbuf_data [BEATS];
  logic [15:0]  wbuf_be   [BEATS];
  logic [1:0]   beat_q;

  logic req_rdy, wdata_rdy;
  logic req_acc, beat_acc;
  logic issue, payload;
  logic cred_ok;
  logic oq_avail, bq_avail, oq_err, bq_err;
  logic inj_flip;

  logic [15:0]  tag_ext;
  logic [63:0]  pa_ext;
  logic [127:0] data_d;
  logic [15:0]  be_d;

  assign cred_ok  = byp_q ? bq_avail : oq_avail;
  assign req_acc  = bus.req_vld & req_rdy;
  assign beat_acc = bus.wdata_vld & wdata_rdy;

  assign bus.req_rdy   = req_rdy;
  assign bus.wdata_rdy = wdata_rdy;

  // FSM next state and handshake decode; ready signals are forced low during reset.
  always_comb begin
    state_d   = state_q;
    req_rdy   = 1'b0;
    wdata_rdy = 1'b0;
    issue     = 1'b0;
    payload   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_rdy = 1'b1;
        if (bus.req_vld) begin
          state_d = bus.req_wr ? ST_COLLECT : ST_HDR;
        end
      end
      ST_COLLECT: begin
        wdata_rdy = 1'b1;
        if (bus.wdata_vld && beat_q == 2'd3) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (cred_ok) begin
          issue = 1'b1;
          if (wr_q) begin
            state_d = ST_PAYLOAD;
          end else begin
            req_rdy = 1'b1;
            if (bus.req_vld) begin
              state_d = bus.req_wr ? ST_COLLECT : ST_HDR;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        payload = 1'b1;
        if (beat_q == 2'd3) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      req_rdy   = 1'b0;
      wdata_rdy = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the request fields on acceptance.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      tag_q <= '0;
      pa_q  <= '0;
      wr_q  <= 1'b0;
      byp_q <= 1'b0;
    end else if (req_acc) begin
      tag_q <= bus.req_tag;
      pa_q  <= bus.req_pa;
      wr_q  <= bus.req_wr;
      byp_q <= bus.req_bypass;
    end
  end

  // Beat pointer: fills the buffer in COLLECT, replays it in PAYLOAD; reset empties the buffer.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      beat_q <= 2'd0;
    end else if (beat_acc || payload) begin
      beat_q <= beat_q + 2'd1;
    end
  end

  // Payload storage needs no reset: it is only replayed after four fresh beats.
  always_ff @(posedge iol2clk) begin
    if (beat_acc) begin
      wbuf_data[beat_q] <= bus.wdata;
      wbuf_be[beat_q]   <= bus.wdata_be;
    end
  end

  niu_sii_cred_cnt #(.MAX(OQ_CREDITS)) u_oq_cred (
    .iol2clk (iol2clk),
    .rst     (rst),
    .inc     (bus.sii_niu_oqdq),
    .dec     (issue & ~byp_q),
    .avail   (oq_avail),
    .err     (oq_err)
  );

  niu_sii_cred_cnt #(.MAX(BQ_CREDITS)) u_bq_cred (
    .iol2clk (iol2clk),
    .rst     (rst),
    .inc     (bus.sii_niu_bqdq),
    .dec     (issue & byp_q),
    .avail   (bq_avail),
    .err     (bq_err)
  );

`ifdef NIU_SII_PAR_INJ_EN
  logic inj_arm_q;

  // One-shot parity corruption: armed by a pulse, consumed by the next header.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      inj_arm_q <= 1'b0;
    end else if (inj_par_err) begin
      inj_arm_q <= 1'b1;
    end else if (issue) begin
      inj_arm_q <= 1'b0;
    end
  end

  assign inj_flip = inj_arm_q & issue;
`else
  assign inj_flip = 1'b0;
`endif

  // Zero-extend latched fields into the fixed header slots.
  always_comb begin
    tag_ext = '0;
    pa_ext  = '0;
    tag_ext[TAG_W-1:0] = tag_q;
    pa_ext[PA_W-1:0]   = pa_q;
  end

  // Next value of the SII data bus: header, payload beat, or idle zero.
  always_comb begin
    data_d = '0;
    be_d   = '0;
    if (issue) begin
      data_d = build_hdr(tag_ext, pa_ext);
    end else if (payload) begin
      data_d = wbuf_data[beat_q];
      be_d   = wbuf_be[beat_q];
    end
  end

  // Registered SII outputs and sticky credit error.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      bus.niu_sii_hdr_vld   <= 1'b0;
      bus.niu_sii_reqbypass <= 1'b0;
      bus.niu_sii_datareq   <= 1'b0;
      bus.niu_sii_datareq16 <= 1'b0;
      bus.niu_sii_data      <= '0;
      bus.niu_sii_parity    <= '0;
      bus.niu_sii_be        <= '0;
      bus.cred_err          <= 1'b0;
    end else begin
      bus.niu_sii_hdr_vld   <= issue;
      bus.niu_sii_reqbypass <= issue & byp_q;
      bus.niu_sii_datareq   <= issue & wr_q;
      bus.niu_sii_datareq16 <= 1'b0;
      bus.niu_sii_data      <= data_d;
      bus.niu_sii_parity    <= calc_par(data_d) ^ {7'b0, inj_flip};
      bus.niu_sii_be        <= be_d;
      bus.cred_err          <= bus.cred_err | oq_err | bq_err;
    end
  end

endmodule

// File: tb/tb_niu_sii_dma_req_tx.sv
// tb/tb_niu_sii_dma_req_tx.sv - directed self-checking bench for niu_sii_dma_req_tx
module tb_niu_sii_dma_req_tx;
  import niu_sii_pkg::*;

  logic iol2clk = 1'b0;
  logic rst     = 1'b1;
`ifdef NIU_SII_PAR_INJ_EN
  logic inj_par_err = 1'b0;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  niu_sii_dma_req_tx_if bus ();

  niu_sii_dma_req_tx dut (
    .iol2clk     (iol2clk),
    .rst         (rst),
`ifdef NIU_SII_PAR_INJ_EN
    .inj_par_err (inj_par_err),
`endif
    .bus         (bus)
  );

  always #5 iol2clk = ~iol2clk;

  task automatic tick();
    @(posedge iol2clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_vld      = 1'b0;
    bus.req_wr       = 1'b0;
    bus.req_bypass   = 1'b0;
    bus.req_tag      = '0;
    bus.req_pa       = '0;
    bus.wdata_vld    = 1'b0;
    bus.wdata        = '0;
    bus.wdata_be     = '0;
    bus.sii_niu_oqdq = 1'b0;
    bus.sii_niu_bqdq = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b0 || bus.niu_sii_data !== 128'h0 || bus.niu_sii_be !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: hdr=%b data=%h be=%h, want 0", bus.niu_sii_hdr_vld, bus.niu_sii_data, bus.niu_sii_be);
    end
    tests_run++;
    if (bus.niu_sii_parity !== 8'h00 || bus.cred_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_parity_err: parity=%h err=%b, want 00/0", bus.niu_sii_parity, bus.cred_err);
    end
    tests_run++;
    if (bus.req_rdy !== 1'b0 || bus.wdata_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rdy: req_rdy=%b wdata_rdy=%b, want 0", bus.req_rdy, bus.wdata_rdy);
    end
    tests_run++;
    if (dut.u_oq_cred.cnt_q !== 5'd16 || dut.u_bq_cred.cnt_q !== 5'd16) begin
      tests_failed++;
      $display("FAIL reset_credits: oq=%0d bq=%0d, want 16/16", dut.u_oq_cred.cnt_q, dut.u_bq_cred.cnt_q);
    end
    rst = 1'b0;
    tick();
    tests_run++;
    if (bus.niu_sii_parity !== 8'hFF || bus.req_rdy !== 1'b1 || bus.wdata_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: parity=%h req_rdy=%b wdata_rdy=%b, want FF/1/0", bus.niu_sii_parity, bus.req_rdy, bus.wdata_rdy);
    end
  endtask

  task automatic test_read();
    apply_reset();
    bus.req_vld = 1'b1;
    bus.req_wr = 1'b0;
    bus.req_bypass = 1'b0;
    bus.req_tag = 16'h00A5;
    bus.req_pa = 40'h12_3456_7880;
    tick();
    bus.req_vld = 1'b0;
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_latency_early: hdr_vld=%b, want 0", bus.niu_sii_hdr_vld);
    end
    tick();
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b1 || bus.niu_sii_datareq !== 1'b0 || bus.niu_sii_reqbypass !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_hdr_ctl: hdr=%b datareq=%b byp=%b, want 1/0/0", bus.niu_sii_hdr_vld, bus.niu_sii_datareq, bus.niu_sii_reqbypass);
    end
    tests_run++;
    if (bus.niu_sii_data !== 128'h0000_0000_0000_00A5_0000_0012_3456_7880 || bus.niu_sii_be !== 16'h0) begin
      tests_failed++;
      $display("FAIL read_hdr_data: data=%h be=%h", bus.niu_sii_data, bus.niu_sii_be);
    end
    tests_run++;
    if (bus.niu_sii_parity !== 8'hFC) begin
      tests_failed++;
      $display("FAIL read_hdr_parity: got %h want FC", bus.niu_sii_parity);
    end
    tests_run++;
    if (dut.u_oq_cred.cnt_q !== 5'd15 || dut.u_bq_cred.cnt_q !== 5'd16) begin
      tests_failed++;
      $display("FAIL read_credit: oq=%0d bq=%0d, want 15/16", dut.u_oq_cred.cnt_q, dut.u_bq_cred.cnt_q);
    end
    tick();
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_single: hdr=%b req_rdy=%b, want 0/1", bus.niu_sii_hdr_vld, bus.req_rdy);
    end
  endtask

  task automatic test_write();
    apply_reset();
    bus.req_vld = 1'b1;
    bus.req_wr = 1'b1;
    bus.req_bypass = 1'b1;
    bus.req_tag = 16'h0011;
    bus.req_pa = 40'h00_0000_0040;
    tick();
    bus.req_vld = 1'b0;
    tests_run++;
    if (bus.wdata_rdy !== 1'b1 || bus.req_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_collect_rdy: wdata_rdy=%b req_rdy=%b, want 1/0", bus.wdata_rdy, bus.req_rdy);
    end
    bus.wdata_vld = 1'b1;
    bus.wdata_be = 16'hFFFF;
    for (int i = 1; i <= 4; i++) begin
      bus.wdata = 128'(i);
      tick();
    end
    bus.wdata_vld = 1'b0;
    tick();
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b1 || bus.niu_sii_datareq !== 1'b1 || bus.niu_sii_reqbypass !== 1'b1 ||
        bus.niu_sii_data !== 128'h0000_0000_0000_0011_0000_0000_0000_0040 || bus.niu_sii_be !== 16'h0) begin
      tests_failed++;
      $display("FAIL write_hdr: hdr=%b datareq=%b byp=%b data=%h be=%h", bus.niu_sii_hdr_vld, bus.niu_sii_datareq, bus.niu_sii_reqbypass, bus.niu_sii_data, bus.niu_sii_be);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      tests_run++;
      if (bus.niu_sii_hdr_vld !== 1'b0 || bus.niu_sii_datareq !== 1'b0 || bus.niu_sii_data !== 128'(i) || bus.niu_sii_be !== 16'hFFFF) begin
        tests_failed++;
        $display("FAIL write_beat%0d: hdr=%b datareq=%b data=%h be=%h, want 0/0/%0d/FFFF", i, bus.niu_sii_hdr_vld, bus.niu_sii_datareq, bus.niu_sii_data, bus.niu_sii_be, i);
      end
    end
    tick();
    tests_run++;
    if (bus.niu_sii_data !== 128'h0 || bus.niu_sii_be !== 16'h0 || bus.req_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_end: data=%h be=%h req_rdy=%b", bus.niu_sii_data, bus.niu_sii_be, bus.req_rdy);
    end
    tests_run++;
    if (dut.u_bq_cred.cnt_q !== 5'd15 || dut.u_oq_cred.cnt_q !== 5'd16) begin
      tests_failed++;
      $display("FAIL write_credit: bq=%0d oq=%0d, want 15/16", dut.u_bq_cred.cnt_q, dut.u_oq_cred.cnt_q);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.req_vld = 1'b1;
    bus.req_tag = 16'h1111;
    bus.req_pa = 40'h00_0000_1000;
    tick();
    bus.req_tag = 16'h2222;
    bus.req_pa = 40'h00_0000_2000;
    tick();
    bus.req_vld = 1'b0;
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b1 || bus.niu_sii_data[79:64] !== 16'h1111) begin
      tests_failed++;
      $display("FAIL b2b_first: hdr=%b tag=%h, want 1/1111", bus.niu_sii_hdr_vld, bus.niu_sii_data[79:64]);
    end
    tick();
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b1 || bus.niu_sii_data[79:64] !== 16'h2222 || bus.niu_sii_data[39:0] !== 40'h00_0000_2000) begin
      tests_failed++;
      $display("FAIL b2b_second: hdr=%b data=%h", bus.niu_sii_hdr_vld, bus.niu_sii_data);
    end
    tick();
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: hdr=%b, want 0", bus.niu_sii_hdr_vld);
    end
  endtask

  task automatic test_oq_exhaust();
    int hdrs;
    apply_reset();
    hdrs = 0;
    bus.req_vld = 1'b1;
    bus.req_tag = 16'h0100;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.niu_sii_hdr_vld === 1'b1) hdrs++;
    end
    tests_run++;
    if (hdrs !== 16 || dut.u_oq_cred.cnt_q !== 5'd0) begin
      tests_failed++;
      $display("FAIL exhaust_count: headers=%0d oq=%0d, want 16/0", hdrs, dut.u_oq_cred.cnt_q);
    end
    tests_run++;
    if (bus.req_rdy !== 1'b0 || dut.state_q !== ST_HDR) begin
      tests_failed++;
      $display("FAIL exhaust_stall: req_rdy=%b state=%0d, want 0/HDR", bus.req_rdy, dut.state_q);
    end
    bus.req_vld = 1'b0;
    bus.sii_niu_oqdq = 1'b1;
    tick();
    bus.sii_niu_oqdq = 1'b0;
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b0 || dut.u_oq_cred.cnt_q !== 5'd1) begin
      tests_failed++;
      $display("FAIL exhaust_dq: hdr=%b oq=%0d, want 0/1", bus.niu_sii_hdr_vld, dut.u_oq_cred.cnt_q);
    end
    tick();
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b1 || dut.u_oq_cred.cnt_q !== 5'd0) begin
      tests_failed++;
      $display("FAIL exhaust_17th: hdr=%b oq=%0d, want 1/0", bus.niu_sii_hdr_vld, dut.u_oq_cred.cnt_q);
    end
    tick();
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b0 || dut.state_q !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL exhaust_done: hdr=%b state=%0d, want 0/IDLE", bus.niu_sii_hdr_vld, dut.state_q);
    end
  endtask

  task automatic test_cred_err();
    apply_reset();
    bus.sii_niu_oqdq = 1'b1;
    tick();
    bus.sii_niu_oqdq = 1'b0;
    tick();
    tests_run++;
    if (dut.u_oq_cred.cnt_q !== 5'd16 || bus.cred_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL overflow: oq=%0d err=%b, want 16/1", dut.u_oq_cred.cnt_q, bus.cred_err);
    end
    bus.req_vld = 1'b1;
    bus.req_tag = 16'h0033;
    tick();
    bus.req_vld = 1'b0;
    bus.sii_niu_oqdq = 1'b1;
    tick();
    bus.sii_niu_oqdq = 1'b0;
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b1 || dut.u_oq_cred.cnt_q !== 5'd16) begin
      tests_failed++;
      $display("FAIL issue_and_dq: hdr=%b oq=%0d, want 1/16", bus.niu_sii_hdr_vld, dut.u_oq_cred.cnt_q);
    end
    tick();
    tick();
    tests_run++;
    if (bus.cred_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: err=%b, want 1", bus.cred_err);
    end
    apply_reset();
    tests_run++;
    if (bus.cred_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_cleared: err=%b, want 0", bus.cred_err);
    end
  endtask

  task automatic test_reset_mid_write();
    int bad;
    apply_reset();
    bus.req_vld = 1'b1;
    bus.req_wr = 1'b1;
    bus.req_tag = 16'h0044;
    tick();
    bus.req_vld = 1'b0;
    bus.req_wr = 1'b0;
    bus.wdata_vld = 1'b1;
    bus.wdata_be = 16'h00FF;
    bus.wdata = 128'hAAAA;
    tick();
    bus.wdata = 128'hBBBB;
    tick();
    rst = 1'b1;
    bus.wdata_vld = 1'b0;
    tick();
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b0 || bus.niu_sii_data !== 128'h0 || bus.niu_sii_be !== 16'h0 ||
        bus.niu_sii_parity !== 8'h00 || dut.state_q !== ST_IDLE || bus.wdata_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_write: hdr=%b data=%h be=%h par=%h state=%0d wrdy=%b", bus.niu_sii_hdr_vld, bus.niu_sii_data, bus.niu_sii_be, bus.niu_sii_parity, dut.state_q, bus.wdata_rdy);
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.niu_sii_hdr_vld !== 1'b0 || bus.niu_sii_data !== 128'h0 || bus.niu_sii_be !== 16'h0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL rst_no_payload: %0d active cycles after reset, want 0", bad);
    end
    bus.req_vld = 1'b1;
    bus.req_tag = 16'h0BEE;
    bus.req_pa = 40'hAB_CDEF_0120;
    tick();
    bus.req_vld = 1'b0;
    tick();
    tests_run++;
    if (bus.niu_sii_hdr_vld !== 1'b1 || bus.niu_sii_datareq !== 1'b0 ||
        bus.niu_sii_data !== 128'h0000_0000_0000_0BEE_0000_00AB_CDEF_0120) begin
      tests_failed++;
      $display("FAIL rst_fresh_read: hdr=%b datareq=%b data=%h", bus.niu_sii_hdr_vld, bus.niu_sii_datareq, bus.niu_sii_data);
    end
  endtask

`ifdef NIU_SII_PAR_INJ_EN
  task automatic test_par_inj();
    apply_reset();
    inj_par_err = 1'b1;
    tick();
    inj_par_err = 1'b0;
    for (int n = 0; n < 2; n++) begin
      bus.req_vld = 1'b1;
      bus.req_tag = 16'h00A5;
      bus.req_pa = 40'h12_3456_7880;
      tick();
      bus.req_vld = 1'b0;
      tick();
      tests_run++;
      if (bus.niu_sii_hdr_vld !== 1'b1 || bus.niu_sii_parity !== ((n == 0) ? 8'hFD : 8'hFC)) begin
        tests_failed++;
        $display("FAIL par_inj_hdr%0d: hdr=%b parity=%h", n, bus.niu_sii_hdr_vld, bus.niu_sii_parity);
      end
      tick();
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_oq_exhaust();
    test_cred_err();
    test_reset_mid_write();
`ifdef NIU_SII_PAR_INJ_EN
    test_par_inj();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
